// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator control sequencer: function codes,
// FSM state encoding and default watchdog sizing.
package calc_sequencer_pkg;

  localparam logic [2:0] F_NOP  = 3'b000;
  localparam logic [2:0] F_ADD  = 3'b001;
  localparam logic [2:0] F_SUB  = 3'b010;
  localparam logic [2:0] F_ADDA = 3'b011;
  localparam logic [2:0] F_SUBA = 3'b100;
  localparam logic [2:0] F_MUL  = 3'b101;
  localparam logic [2:0] F_CLR  = 3'b110;
  localparam logic [2:0] F_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  localparam int DEF_MUL_TIMEOUT = 40;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/calc_mul_watchdog.sv
// Multiplier watchdog: clearable up-counter flagging the last allowed wait cycle.
module calc_mul_watchdog #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 1'b1;
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: per-instruction strobes and multiplier handshake.
// Optional CALC_SEQ_PERF_EN adds retired-instruction and stall counters.
//
// state      | meaning
// S_IDLE     | parked, all outputs low, waits for run
// S_EXEC     | one instruction per cycle, Mealy strobes from funct
// S_MUL_WAIT | multiplier running, PC stalled, watchdog counting
// S_HALT     | HALT executed, waits for run low
// S_ERR      | multiplier timeout, leaves only on reset
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int MUL_TIMEOUT = DEF_MUL_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [2:0]  funct,
  input  logic        mul_done,
  output logic        pc_en,
  output logic        accum_we,
  output logic        accum_clr,
  output logic        sign_ctl,
  output logic        store_prev,
  output logic        op_sel,
  output logic        mul_start,
  output logic        busy,
  output logic        halted,
  output logic        err
`ifdef CALC_SEQ_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_t state, state_nxt;
  logic   wd_expired;

  calc_mul_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (MUL_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != S_MUL_WAIT),
    .en      (state == S_MUL_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b0;
    accum_we   = 1'b0;
    accum_clr  = 1'b0;
    sign_ctl   = 1'b0;
    store_prev = 1'b0;
    op_sel     = 1'b0;
    mul_start  = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_EXEC;
      S_EXEC: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end else begin
          case (funct)
            F_NOP: pc_en = 1'b1;
            F_ADD, F_SUB, F_ADDA, F_SUBA: begin
              accum_we   = 1'b1;
              pc_en      = 1'b1;
              sign_ctl   = (funct == F_SUB) || (funct == F_SUBA);
              store_prev = (funct == F_ADD) || (funct == F_SUB);
            end
            F_MUL: begin
              mul_start = 1'b1;
              state_nxt = S_MUL_WAIT;
            end
            F_CLR: begin
              accum_clr = 1'b1;
              accum_we  = 1'b1;
              pc_en     = 1'b1;
            end
            F_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_EXEC;
          endcase
        end
      end
      S_MUL_WAIT: begin
        op_sel = 1'b1;
        // a result arriving on the final watchdog cycle still retires
        if (mul_done) begin
          accum_we  = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_EXEC;
        end else if (wd_expired) begin
          state_nxt = S_ERR;
        end
      end
      S_HALT:  if (!run) state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state == S_EXEC) || (state == S_MUL_WAIT);
  assign halted = (state == S_HALT);
  assign err    = (state == S_ERR);

`ifdef CALC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      retired_cnt <= retired_cnt + 32'(pc_en);
      stall_cnt   <= stall_cnt + 32'(state == S_MUL_WAIT);
    end
  end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: vector table plus multi-cycle sequences.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [2:0] funct;
  logic       mul_done;
  logic pc_en, accum_we, accum_clr, sign_ctl, store_prev, op_sel, mul_start;
  logic busy, halted, err;
`ifdef CALC_SEQ_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  calc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .funct      (funct),
    .mul_done   (mul_done),
    .pc_en      (pc_en),
    .accum_we   (accum_we),
    .accum_clr  (accum_clr),
    .sign_ctl   (sign_ctl),
    .store_prev (store_prev),
    .op_sel     (op_sel),
    .mul_start  (mul_start),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
`ifdef CALC_SEQ_PERF_EN
    ,
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // order: pc_en accum_we accum_clr sign_ctl store_prev op_sel mul_start busy halted err
  logic [9:0] obs;
  assign obs = {pc_en, accum_we, accum_clr, sign_ctl, store_prev,
                op_sel, mul_start, busy, halted, err};

  localparam logic [9:0] O_ZERO = 10'b0000000000;
  localparam logic [9:0] O_BUSY = 10'b0000000100;
  localparam logic [9:0] O_ADD  = 10'b1100100100;
  localparam logic [9:0] O_SUB  = 10'b1101100100;
  localparam logic [9:0] O_ADDA = 10'b1100000100;
  localparam logic [9:0] O_SUBA = 10'b1101000100;
  localparam logic [9:0] O_NOP  = 10'b1000000100;
  localparam logic [9:0] O_CLR  = 10'b1110000100;
  localparam logic [9:0] O_MST  = 10'b0000001100;
  localparam logic [9:0] O_MWT  = 10'b0000010100;
  localparam logic [9:0] O_MRET = 10'b1100010100;
  localparam logic [9:0] O_HALT = 10'b0000000010;
  localparam logic [9:0] O_ERR  = 10'b0000000001;

  typedef struct packed {
    logic       run;
    logic [2:0] funct;
    logic       mul_done;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic r, logic [2:0] f, logic d, logic [9:0] e);
    vec_t v;
    v.run = r; v.funct = f; v.mul_done = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // inputs change at posedge+1, outputs are sampled at the following negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; funct = 3'b000; mul_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n_start;
    int bad;
    vecs[0]  = mk(1'b0, 3'b000, 1'b0, O_ZERO);
    vecs[1]  = mk(1'b1, 3'b001, 1'b0, O_ZERO);
    vecs[2]  = mk(1'b1, 3'b001, 1'b0, O_ADD);
    vecs[3]  = mk(1'b1, 3'b010, 1'b0, O_SUB);
    vecs[4]  = mk(1'b1, 3'b011, 1'b0, O_ADDA);
    vecs[5]  = mk(1'b1, 3'b100, 1'b0, O_SUBA);
    vecs[6]  = mk(1'b1, 3'b000, 1'b0, O_NOP);
    vecs[7]  = mk(1'b1, 3'b110, 1'b0, O_CLR);
    vecs[8]  = mk(1'b0, 3'b001, 1'b0, O_BUSY);
    vecs[9]  = mk(1'b0, 3'b001, 1'b0, O_ZERO);
    vecs[10] = mk(1'b1, 3'b111, 1'b0, O_ZERO);
    vecs[11] = mk(1'b1, 3'b111, 1'b0, O_BUSY);
    vecs[12] = mk(1'b1, 3'b111, 1'b0, O_HALT);
    vecs[13] = mk(1'b1, 3'b001, 1'b0, O_HALT);
    vecs[14] = mk(1'b0, 3'b001, 1'b0, O_HALT);
    vecs[15] = mk(1'b1, 3'b001, 1'b0, O_ZERO);
    vecs[16] = mk(1'b1, 3'b001, 1'b0, O_ADD);
    vecs[17] = mk(1'b1, 3'b101, 1'b1, O_MST);
    vecs[18] = mk(1'b0, 3'b001, 1'b0, O_MWT);
    vecs[19] = mk(1'b0, 3'b001, 1'b1, O_MRET);
    vecs[20] = mk(1'b0, 3'b001, 1'b0, O_BUSY);
    vecs[21] = mk(1'b0, 3'b000, 1'b0, O_ZERO);

    do_reset();
    @(negedge clk);
    chk("reset_state", 32'(obs), 32'(O_ZERO));
`ifdef CALC_SEQ_PERF_EN
    chk("perf_reset", retired_cnt | stall_cnt, 32'd0);
`endif
    next_cycle();

    for (int i = 0; i < 22; i++) begin
      run = vecs[i].run; funct = vecs[i].funct; mul_done = vecs[i].mul_done;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
      next_cycle();
    end

    // multiply with mul_done arriving five cycles after the start pulse
    do_reset();
    run = 1'b1; funct = 3'b101;
    next_cycle();
    n_start = 0; bad = 0;
    for (int i = 0; i <= 5; i++) begin
      mul_done = (i == 5);
      @(negedge clk);
      n_start += int'(mul_start);
      if (i == 0 && obs !== O_MST) bad++;
      if (i > 0 && i < 5 && obs !== O_MWT) bad++;
      if (i == 5) chk("mul_retire", 32'(obs), 32'(O_MRET));
      next_cycle();
    end
    chk("mul_start_count", n_start, 1);
    chk("mul_wait_stall", bad, 0);

    // no mul_done: forty wait cycles then sticky err
    do_reset();
    run = 1'b1; funct = 3'b101;
    next_cycle();
    next_cycle();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (obs !== O_MWT) bad++;
      next_cycle();
    end
    chk("timeout_wait", bad, 0);
    @(negedge clk);
    chk("timeout_err", 32'(obs), 32'(O_ERR));
    next_cycle();
    run = 1'b0; next_cycle();
    run = 1'b1; mul_done = 1'b1; next_cycle();
    @(negedge clk);
    chk("err_sticky", 32'(obs), 32'(O_ERR));
    do_reset();
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);

    // mul_done on the last watchdog cycle retires normally
    run = 1'b1; funct = 3'b101;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 40; i++) begin
      mul_done = (i == 39);
      @(negedge clk);
      if (i == 39) chk("done_at_timeout", 32'(obs), 32'(O_MRET));
      next_cycle();
    end
    funct = 3'b000; mul_done = 1'b0;
    @(negedge clk);
    chk("no_err_after_late_done", 32'(obs), 32'(O_NOP));

    // asynchronous reset in the middle of an ADD cycle
    next_cycle();
    funct = 3'b001;
    @(negedge clk);
    chk("pre_async_reset", 32'(obs), 32'(O_ADD));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(obs), 32'(O_ZERO));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", 32'(obs), 32'(O_ZERO));
    next_cycle();
    @(negedge clk);
    chk("after_reset_exec", 32'(obs), 32'(O_ADD));

    // reset during MUL_WAIT discards the pending result
    next_cycle();
    funct = 3'b101;
    next_cycle();
    @(negedge clk);
    chk("mid_mul_wait", 32'(obs), 32'(O_MWT));
    reset = 1'b1;
    #1;
    chk("mid_mul_reset", 32'(obs), 32'(O_ZERO));
    next_cycle();
    reset = 1'b0; funct = 3'b001; mul_done = 1'b1;
    @(negedge clk);
    chk("mid_mul_idle", 32'(obs), 32'(O_ZERO));
    next_cycle();
    @(negedge clk);
    chk("mid_mul_resume", 32'(obs), 32'(O_ADD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
